// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the LC3 fetch/data requesters, the shared memory and the arbiter.
// The master side is the environment (both requesters plus the memory); the slave side is the arbiter.
interface lc3_mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_dout;
  logic        i_complete;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_din;
  logic [15:0] d_dout;
  logic        d_complete;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_dout;
  logic        mem_complete;
  logic        err;

  modport slave (
    input  i_req, i_addr, d_rd, d_wr, d_addr, d_din, mem_dout, mem_complete,
    output i_dout, i_complete, d_dout, d_complete, mem_addr, mem_din, mem_rd, mem_wr, err
  );

  modport master (
    output i_req, i_addr, d_rd, d_wr, d_addr, d_din, mem_dout, mem_complete,
    input  i_dout, i_complete, d_dout, d_complete, mem_addr, mem_din, mem_rd, mem_wr, err
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Shares one 16-bit memory port between LC3 instruction fetch and data access:
// data-first priority with a fetch starvation guard, minimum wait and timeout per access.
module lc3_mem_arbiter #(
  parameter int MIN_WAIT    = 2,
  parameter int TIMEOUT     = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic               clock,
  input  logic               reset,
  lc3_mem_arbiter_if.slave   bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int STRK_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [WAIT_W-1:0] WAIT_MIN  = WAIT_W'(MIN_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [STRK_W-1:0]   streak_q, streak_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [15:0]         mem_din_q, mem_din_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [15:0]         i_dout_q, i_dout_d;
  logic [15:0]         d_dout_q, d_dout_d;
  logic                i_complete_q, i_complete_d;
  logic                d_complete_q, d_complete_d;
  logic                err_q, err_d;
  logic                d_req;

  assign d_req = bus.d_rd | bus.d_wr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      streak_q     <= '0;
      mem_addr_q   <= 16'h0000;
      mem_din_q    <= 16'h0000;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      i_dout_q     <= 16'h0000;
      d_dout_q     <= 16'h0000;
      i_complete_q <= 1'b0;
      d_complete_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      streak_q     <= streak_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      i_dout_q     <= i_dout_d;
      d_dout_q     <= d_dout_d;
      i_complete_q <= i_complete_d;
      d_complete_q <= d_complete_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    streak_d     = streak_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    i_dout_d     = i_dout_q;
    d_dout_d     = d_dout_q;
    i_complete_d = 1'b0;
    d_complete_d = 1'b0;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        // Data wins unless it has already taken MAX_DSTREAK grants past a waiting fetch.
        if (d_req && (!bus.i_req || (streak_q < STRK_MAX))) begin
          state_d    = DBUSY;
          mem_addr_d = bus.d_addr;
          mem_din_d  = bus.d_din;
          mem_rd_d   = bus.d_rd;
          mem_wr_d   = ~bus.d_rd;
          wait_d     = '0;
          if (!bus.i_req)
            streak_d = '0;
          else if (streak_q != STRK_MAX)
            streak_d = streak_q + STRK_W'(1);
        end else if (bus.i_req) begin
          state_d    = IBUSY;
          mem_addr_d = bus.i_addr;
          mem_din_d  = 16'h0000;
          mem_rd_d   = 1'b1;
          mem_wr_d   = 1'b0;
          wait_d     = '0;
          streak_d   = '0;
        end
      end

      IBUSY, DBUSY: begin
        wait_d = wait_q + WAIT_W'(1);
        if (bus.mem_complete && (wait_q >= WAIT_MIN)) begin
          state_d  = RESP;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (state_q == IBUSY) begin
            i_dout_d     = bus.mem_dout;
            i_complete_d = 1'b1;
          end else begin
            if (mem_rd_q)
              d_dout_d = bus.mem_dout;
            d_complete_d = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d  = RESP;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          err_d    = 1'b1;
          if (state_q == IBUSY) begin
            i_dout_d     = 16'h0000;
            i_complete_d = 1'b1;
          end else begin
            d_dout_d     = 16'h0000;
            d_complete_d = 1'b1;
          end
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.i_dout     = i_dout_q;
  assign bus.d_dout     = d_dout_q;
  assign bus.i_complete = i_complete_q;
  assign bus.d_complete = d_complete_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: a 16-word memory model with programmable readiness
// and a transaction-level reference model predicting winner, latency, data and err.
module tb_lc3_mem_arbiter;
  localparam int MIN_WAIT    = 2;
  localparam int TIMEOUT     = 64;
  localparam int MAX_DSTREAK = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  lc3_mem_arbiter_if bus ();

  lc3_mem_arbiter #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT), .MAX_DSTREAK(MAX_DSTREAK)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Memory model: readiness held low for memLow strobe cycles, or forever when memStuck.
  logic [15:0] memArr [16];
  logic        pokeEn = 1'b0;
  logic [3:0]  pokeAddr = '0;
  logic [15:0] pokeData = '0;
  int          strobeCnt = 0;
  int          memLow = 0;
  bit          memStuck = 1'b0;

  always @(posedge clock) begin
    if (bus.mem_wr === 1'b1) memArr[bus.mem_addr[3:0]] <= bus.mem_din;
    else if (pokeEn)         memArr[pokeAddr] <= pokeData;
    strobeCnt <= ((bus.mem_rd | bus.mem_wr) === 1'b1) ? strobeCnt + 1 : 0;
  end
  assign bus.mem_dout     = memArr[bus.mem_addr[3:0]];
  assign bus.mem_complete = !memStuck && (strobeCnt >= memLow);

  // Reference model state
  logic [15:0] modelMem [16];
  logic [15:0] iOutModel = 16'h0000;
  logic [15:0] dOutModel = 16'h0000;
  bit          errModel = 1'b0;
  int          streak = 0;
  bit          afterResp = 1'b0;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic pokeMem(input logic [3:0] a, input logic [15:0] v);
    pokeAddr = a; pokeData = v; pokeEn = 1'b1;
    @(posedge clock); #1;
    pokeEn = 1'b0;
    modelMem[a] = v;
  endtask

  task automatic tick();
    @(posedge clock); #1;
    afterResp = 1'b0;
  endtask

  // Serves one access from the current request levels and checks it against the model.
  task automatic serveOne(input int lowCycles, input bit stuck, output bit gotD);
    bit expD, expWrite, done, shapeOk;
    logic [15:0] expAddr, expDin, expOut;
    int expBusy, expLat, c, busy;
    expD     = (bus.d_rd | bus.d_wr) && (!bus.i_req || streak < MAX_DSTREAK);
    expWrite = expD && bus.d_wr && !bus.d_rd;
    expAddr  = expD ? bus.d_addr : bus.i_addr;
    expDin   = bus.d_din;
    if (expD) streak = bus.i_req ? ((streak < MAX_DSTREAK) ? streak + 1 : streak) : 0;
    else      streak = 0;
    expBusy  = stuck ? TIMEOUT : ((lowCycles + 1 > MIN_WAIT) ? lowCycles + 1 : MIN_WAIT);
    expLat   = expBusy + (afterResp ? 2 : 1);
    if (stuck)         expOut = 16'h0000;
    else if (expWrite) expOut = dOutModel;
    else               expOut = modelMem[expAddr[3:0]];
    memLow = lowCycles; memStuck = stuck;
    c = 0; busy = 0; done = 1'b0; shapeOk = 1'b1;
    while (!done && c < 200) begin
      @(posedge clock); #1;
      c++;
      if ((bus.mem_rd | bus.mem_wr) === 1'b1) begin
        busy++;
        if (bus.mem_addr !== expAddr || bus.mem_wr !== expWrite || bus.mem_rd !== !expWrite) shapeOk = 1'b0;
        if (expWrite && bus.mem_din !== expDin) shapeOk = 1'b0;
      end
      if ((bus.i_complete | bus.d_complete) === 1'b1) done = 1'b1;
    end
    checkBit("completion_seen", done, 1'b1);
    check16("latency", 16'(c), 16'(expLat));
    check16("strobe_cycles", 16'(busy), 16'(expBusy));
    checkBit("strobe_addr_data", shapeOk, 1'b1);
    checkBit("i_complete", bus.i_complete, !expD);
    checkBit("d_complete", bus.d_complete, expD);
    gotD = (bus.d_complete === 1'b1);
    if (expD) dOutModel = expOut; else iOutModel = expOut;
    if (expWrite && !stuck) modelMem[expAddr[3:0]] = expDin;
    if (stuck) errModel = 1'b1;
    check16("i_dout", bus.i_dout, iOutModel);
    check16("d_dout", bus.d_dout, dOutModel);
    checkBit("err", bus.err, errModel);
    if (expD) begin bus.d_rd = 1'b0; bus.d_wr = 1'b0; end
    else bus.i_req = 1'b0;
    memLow = 0; memStuck = 1'b0;
    afterResp = 1'b1;
  endtask

  initial begin
    bit gotD;
    string seqStr;
    int gap, maxGap, r;
    bus.i_req = 1'b0; bus.i_addr = 16'h0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    bus.d_addr = 16'h0; bus.d_din = 16'h0;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) pokeMem(4'(i), 16'($urandom));
    checkBit("rst_mem_rd", bus.mem_rd, 1'b0);
    checkBit("rst_mem_wr", bus.mem_wr, 1'b0);
    checkBit("rst_i_complete", bus.i_complete, 1'b0);
    checkBit("rst_d_complete", bus.d_complete, 1'b0);
    checkBit("rst_err", bus.err, 1'b0);
    check16("rst_mem_addr", bus.mem_addr, 16'h0000);
    check16("rst_i_dout", bus.i_dout, 16'h0000);
    reset = 1'b1;
    tick();

    // Fetch only from an always-ready memory
    pokeMem(4'h0, 16'h1234);
    bus.i_req = 1'b1; bus.i_addr = 16'h3000;
    afterResp = 1'b0;
    serveOne(0, 1'b0, gotD);
    check16("fetch_1234", bus.i_dout, 16'h1234);
    tick();

    // Data write then read back
    bus.d_wr = 1'b1; bus.d_addr = 16'h300A; bus.d_din = 16'h0002;
    serveOne(0, 1'b0, gotD);
    tick();
    bus.d_rd = 1'b1; bus.d_addr = 16'h300A; bus.d_din = 16'hFFFF;
    serveOne(0, 1'b0, gotD);
    check16("readback_0002", bus.d_dout, 16'h0002);
    tick();

    // Slow memory: ten not-ready strobe cycles
    bus.i_req = 1'b1; bus.i_addr = 16'h300A;
    serveOne(10, 1'b0, gotD);
    tick();

    // Contention: both requests re-issued immediately after each completion
    bus.i_req = 1'b1; bus.i_addr = 16'h3100;
    bus.d_rd = 1'b1; bus.d_addr = 16'h3104;
    seqStr = ""; gap = 0; maxGap = 0;
    for (int k = 0; k < 10; k++) begin
      serveOne(0, 1'b0, gotD);
      seqStr = {seqStr, gotD ? "D" : "I"};
      gap++;
      if (!gotD) begin
        if (gap > maxGap) maxGap = gap;
        gap = 0;
      end
      if (gotD) bus.d_rd = 1'b1; else bus.i_req = 1'b1;
    end
    checks++;
    assert (seqStr == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL grant_order observed=%s expected=DDDDIDDDDI", seqStr);
    end
    checkBit("fetch_gap_le5", maxGap <= 5, 1'b1);
    while ((bus.i_req | bus.d_rd | bus.d_wr) === 1'b1) serveOne(0, 1'b0, gotD);
    tick();

    // Randomized traffic; the losing requester stays pending
    for (int n = 0; n < 40; n++) begin
      if (!bus.i_req && $urandom_range(0, 1) == 1) begin
        bus.i_req = 1'b1; bus.i_addr = 16'($urandom);
      end
      if (!(bus.d_rd | bus.d_wr) && $urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 2);
        bus.d_rd = (r != 1); bus.d_wr = (r != 0);
        bus.d_addr = 16'($urandom); bus.d_din = 16'($urandom);
      end
      if (!(bus.i_req | bus.d_rd | bus.d_wr)) begin
        bus.i_req = 1'b1; bus.i_addr = 16'($urandom);
      end
      serveOne($urandom_range(0, 5), 1'b0, gotD);
    end
    while ((bus.i_req | bus.d_rd | bus.d_wr) === 1'b1) serveOne(0, 1'b0, gotD);
    tick();

    // Timeout on a fetch, then err stays set through a good access
    bus.i_req = 1'b1; bus.i_addr = 16'h3001;
    serveOne(0, 1'b1, gotD);
    check16("timeout_i_dout", bus.i_dout, 16'h0000);
    tick();
    bus.d_rd = 1'b1; bus.d_addr = 16'h3002;
    serveOne(1, 1'b0, gotD);
    tick();

    // Reset in the second DBUSY cycle
    bus.d_rd = 1'b1; bus.d_addr = 16'h3005; memStuck = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkBit("pre_reset_mem_rd", bus.mem_rd, 1'b1);
    reset = 1'b0;
    @(posedge clock); #1;
    checkBit("mid_reset_mem_rd", bus.mem_rd, 1'b0);
    checkBit("mid_reset_mem_wr", bus.mem_wr, 1'b0);
    checkBit("mid_reset_d_complete", bus.d_complete, 1'b0);
    checkBit("mid_reset_err", bus.err, 1'b0);
    check16("mid_reset_d_dout", bus.d_dout, 16'h0000);
    bus.d_rd = 1'b0; memStuck = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    iOutModel = 16'h0000; dOutModel = 16'h0000; errModel = 1'b0; streak = 0;
    @(posedge clock); #1;
    afterResp = 1'b0;
    checkBit("post_reset_d_complete", bus.d_complete, 1'b0);
    bus.d_rd = 1'b1; bus.d_addr = 16'h3005;
    serveOne(0, 1'b0, gotD);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares one 16-bit memory port between the LC3 instruction-fetch requester and its data-access requester, replacing separate instruction and data memories.
- Arbitrates between the two requesters with data-first priority and a starvation guard for fetch.
- Sequences each access through a small FSM and returns data plus a one-cycle completion pulse to the winning requester.
- Provides a per-access timeout against a stalled memory.

Parameters:
- MIN_WAIT, 2, minimum cycles in BUSY before mem_complete is honoured; covers a synchronous RAM whose complete is tied high.
- TIMEOUT, 64, BUSY cycles after which the access is aborted; must be greater than MIN_WAIT.
- MAX_DSTREAK, 4, consecutive data grants allowed while a fetch is pending.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- i_req  in  1  fetch request, level; held until i_complete seen
- i_addr  in  16  fetch address
- i_dout  out  16  fetched instruction
- i_complete  out  1  one-cycle fetch completion pulse
- d_rd  in  1  data read request, level
- d_wr  in  1  data write request, level
- d_addr  in  16  data address
- d_din  in  16  write data
- d_dout  out  16  read data
- d_complete  out  1  one-cycle data completion pulse
- mem_addr  out  16  shared memory address
- mem_din  out  16  shared memory write data
- mem_rd  out  1  memory read strobe, held for the whole access
- mem_wr  out  1  memory write strobe, held for the whole access
- mem_dout  in  16  memory read data
- mem_complete  in  1  memory ready/valid qualifier
- err  out  1  sticky: an access timed out

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - mem_rd, mem_wr, i_complete, d_complete and err go to 0.
  - i_dout, d_dout, mem_addr and mem_din go to 16'h0000.
  - Streak and wait counters clear.
  - Reset mid-access abandons the access; no completion pulse is issued. Strobes are low from the first cycle after the reset edge.
- Data request definition: d_req = d_rd | d_wr. If d_rd and d_wr are both high, the access is a read.
- FSM states: IDLE, IBUSY, DBUSY, RESP. All outputs are registered.
- IDLE arbitration:
  - Grant data if d_req and (!i_req or streak < MAX_DSTREAK).
  - Otherwise grant fetch if i_req.
  - Otherwise stay in IDLE.
  - On the grant edge: latch address and write data into mem_addr/mem_din, set mem_rd or mem_wr, clear the wait counter.
- Streak counter:
  - +1 on each data grant made while i_req is high.
  - Clears on any fetch grant, and on any data grant made while i_req is low.
  - Saturates at MAX_DSTREAK.
- IBUSY/DBUSY:
  - The wait counter increments every cycle.
  - mem_addr, mem_din and the strobes stay stable.
  - Completion: if mem_complete==1 and wait >= MIN_WAIT-1, capture mem_dout into i_dout or d_dout (reads only; d_dout holds on writes), drop the strobes, go to RESP.
  - Timeout: if wait reaches TIMEOUT-1 without completion, drop the strobes, set err, load 16'h0000 into the target dout, go to RESP.
- RESP:
  - Exactly one cycle.
  - The completion pulse of the served requester is 1; the other requester's pulse stays 0.
  - Next state is IDLE.
- Requester contract:
  - Drop the request, or present a new one, at the edge ending the completion cycle.
  - IDLE therefore never re-serves a stale request.
- Latency: request first seen in IDLE at cycle 0 gives BUSY in cycles 1..MIN_WAIT, RESP in cycle MIN_WAIT+1, completion visible then. With defaults and an always-ready memory this is 4 cycles from request to next grant.
- Simultaneous i_req and d_req in IDLE: data wins unless the streak is saturated, in which case fetch wins.
- Request changes during BUSY/RESP are ignored; sampling happens only in IDLE.
- Address and data widths are fixed at 16 bits, with no wrap logic; addresses pass through unmodified.
- err clears only on reset.

Test Plan:
1. Fetch only: i_req=1, i_addr=16'h3000, memory holds 16'h1234, mem_complete=1 → mem_rd high cycles 1–2, i_complete pulses in cycle 3 with i_dout=16'h1234; d_complete stays 0.
2. Data write then read: d_wr, d_addr=16'h300A, d_din=16'h0002, then d_rd at the same address → mem_wr held 2 cycles with mem_din=16'h0002; the read returns d_dout=16'h0002; d_dout unchanged after the write.
3. Contention/starvation: i_req and d_rd held high continuously, requests re-issued immediately after each completion → grant order D,D,D,D,I,D,D,D,D,I; i_complete never more than 5 accesses apart.
4. Slow memory: mem_complete low for 10 BUSY cycles then high → strobes held 11 cycles, a single completion pulse, err=0.
5. Timeout: mem_complete stuck low on a fetch → RESP after 64 BUSY cycles, i_dout=16'h0000, err=1 and staying 1 through later good accesses.
6. Reset mid-access: reset=0 in the second DBUSY cycle → next cycle mem_rd=mem_wr=0, no d_complete, state IDLE; a new request after reset=1 is served normally.
